pc_fetch_sequencer: RTL and testbench



---
 rtl/pc_seq_pkg.sv | 13 +
 rtl/pc_redirect_buffer.sv | 44 ++++
 rtl/pc_fetch_sequencer.sv | 141 ++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and defaults for the PC fetch sequencer.
//   seq_state_e  - sequencer state (HOLD, RUN, STALLED, FLUSH)
//   redir_kind_e - kind of a redirect (NONE, BR, JMP)
//   *_DEF        - default parameter values for the top
package pc_seq_pkg;

   typedef enum logic [1:0] {HOLD, RUN, STALLED, FLUSH} seq_state_e;
   typedef enum logic [1:0] {NONE, BR, JMP}             redir_kind_e;

   localparam int INSTR_BYTES_DEF = 4;
   localparam int LAST_ADDR_DEF   = 36;

endpackage

// File: rtl/pc_redirect_buffer.sv
// pc_redirect_buffer: holds one redirect that arrived while fetch was stalled.
//   Clk, Reset   - clock, async active-high reset (clears the entry)
//   capture      - offer cap_kind/cap_target this cycle (ignored if kind NONE)
//   clear        - drop the entry (takes precedence over capture)
//   pend_valid   - an entry is held
//   pend_kind    - BR or JMP of the held entry (NONE when empty)
//   pend_target  - aligned target of the held entry
module pc_redirect_buffer
   import pc_seq_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              capture,
   input  redir_kind_e       cap_kind,
   input  logic [ADDR_W-1:0] cap_target,
   input  logic              clear,
   output logic              pend_valid,
   output redir_kind_e       pend_kind,
   output logic [ADDR_W-1:0] pend_target
);

   // A held branch is from an older instruction than any later jump, so a
   // jump must not displace it; anything else overwrites.
   logic keep_old;
   assign keep_old = (pend_kind == BR) && (cap_kind == JMP);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pend_kind   <= NONE;
         pend_target <= '0;
      end else if (clear) begin
         pend_kind   <= NONE;
         pend_target <= '0;
      end else if (capture && (cap_kind != NONE) && !keep_old) begin
         pend_kind   <= cap_kind;
         pend_target <= cap_target;
      end
   end

   assign pend_valid = (pend_kind != NONE);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: next-address controller for the program counter.
//   Clk, Reset               - clock, async active-high reset
//   PCCurrent                - current PC register value
//   Stall                    - hazard unit fetch hold request
//   BranchTaken/BranchTarget - resolved taken branch and destination
//   Jump/JumpTarget          - decoded jump and destination
//   Address                  - next PC (combinational)
//   FetchValid               - instruction at PCCurrent is architecturally valid
//   Flush                    - squash IF/ID
//   Wrapped                  - pulse when the next address wraps to 0
module pc_fetch_sequencer
   import pc_seq_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int INSTR_BYTES  = INSTR_BYTES_DEF,
   parameter int LAST_ADDR    = LAST_ADDR_DEF,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] PCCurrent,
   input  logic              Stall,
   input  logic              BranchTaken,
   input  logic [ADDR_W-1:0] BranchTarget,
   input  logic              Jump,
   input  logic [ADDR_W-1:0] JumpTarget,
   output logic [ADDR_W-1:0] Address,
   output logic              FetchValid,
   output logic              Flush,
   output logic              Wrapped
);

   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INSTR_BYTES - 1);
   localparam logic [ADDR_W-1:0] LAST       = ADDR_W'(LAST_ADDR);
   localparam logic [1:0]        CNT_INIT   = 2'(FLUSH_CYCLES);

   seq_state_e        state, nstate;
   logic [1:0]        cnt;
   logic              cnt_load;

   redir_kind_e       rd_kind;
   logic [ADDR_W-1:0] br_tgt, jp_tgt, rd_tgt, incr, sel;
   logic              in_hold, wrap_hit;

   logic              cap, clr, pend_valid;
   redir_kind_e       pend_kind;
   logic [ADDR_W-1:0] pend_target;

   // Branch wins over jump: it belongs to the older instruction.
   assign br_tgt  = BranchTarget & ALIGN_MASK;
   assign jp_tgt  = JumpTarget & ALIGN_MASK;
   assign rd_kind = BranchTaken ? BR : (Jump ? JMP : NONE);
   assign rd_tgt  = BranchTaken ? br_tgt : jp_tgt;
   assign incr    = PCCurrent + ADDR_W'(INSTR_BYTES);

   pc_redirect_buffer #(.ADDR_W(ADDR_W)) u_rbuf (
      .Clk         (Clk),
      .Reset       (Reset),
      .capture     (cap),
      .cap_kind    (rd_kind),
      .cap_target  (rd_tgt),
      .clear       (clr),
      .pend_valid  (pend_valid),
      .pend_kind   (pend_kind),
      .pend_target (pend_target)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= HOLD;
         cnt   <= '0;
      end else begin
         state <= nstate;
         if (cnt_load)
            cnt <= CNT_INIT;
         else if (state == FLUSH && cnt != 2'd0)
            cnt <= cnt - 2'd1;
      end
   end

   always_comb begin
      nstate     = state;
      sel        = incr;
      FetchValid = 1'b0;
      Flush      = 1'b0;
      in_hold    = 1'b0;
      cap        = 1'b0;
      clr        = 1'b0;
      cnt_load   = 1'b0;
      case (state)
         HOLD: begin
            in_hold = 1'b1;
            nstate  = RUN;
         end
         RUN: begin
            FetchValid = 1'b1;
            if (rd_kind != NONE && !Stall) begin
               sel      = rd_tgt;
               cnt_load = 1'b1;
               nstate   = FLUSH;
            end else if (Stall) begin
               sel    = PCCurrent;
               cap    = 1'b1;
               nstate = STALLED;
            end
         end
         STALLED: begin
            if (Stall) begin
               sel = PCCurrent;
               cap = 1'b1;
            end else if (pend_valid) begin
               sel      = pend_target;
               clr      = 1'b1;
               cnt_load = 1'b1;
               nstate   = FLUSH;
            end else if (rd_kind != NONE) begin
               sel      = rd_tgt;
               cnt_load = 1'b1;
               nstate   = FLUSH;
            end else begin
               nstate = RUN;
            end
         end
         FLUSH: begin
            Flush = 1'b1;
            // Jumps here come from squashed instructions; only a branch counts.
            if (BranchTaken) begin
               sel      = br_tgt;
               cnt_load = 1'b1;
            end else if (cnt <= 2'd1) begin
               nstate = RUN;
            end
         end
      endcase
   end

   assign wrap_hit = !in_hold && (sel > LAST);
   assign Wrapped  = wrap_hit;
   assign Address  = (in_hold || wrap_hit) ? '0 : sel;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;

   localparam int IB = 4;
   localparam int LA = 36;
   localparam int FC = 1;

   logic        Clk = 1'b0;
   logic        Reset, Stall, BranchTaken, Jump;
   logic [31:0] PCCurrent, BranchTarget, JumpTarget, Address;
   logic        FetchValid, Flush, Wrapped;

   int errors = 0;
   int checks = 0;

   always #5 Clk = ~Clk;

   pc_fetch_sequencer #(.ADDR_W(32), .INSTR_BYTES(IB), .LAST_ADDR(LA), .FLUSH_CYCLES(FC)) dut (
      .Clk(Clk), .Reset(Reset), .PCCurrent(PCCurrent), .Stall(Stall),
      .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
      .Jump(Jump), .JumpTarget(JumpTarget), .Address(Address),
      .FetchValid(FetchValid), .Flush(Flush), .Wrapped(Wrapped)
   );

   // Reference model: mode flags, remaining flush cycles and a one-slot
   // pending redirect, stepped once per clock from the rules.
   bit          m_hold, m_stalled, m_pv, m_pbr;
   int          m_flush;
   logic [31:0] m_pt;
   bit          n_hold, n_stalled, n_pv, n_pbr;
   int          n_flush;
   logic [31:0] n_pt;
   logic [31:0] e_addr, nxt;
   bit          e_fv, e_fl, e_wr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_hold = 1; m_stalled = 0; m_flush = 0; m_pv = 0; m_pbr = 0; m_pt = '0;
   endtask

   task automatic model_eval();
      logic [31:0] tb_, tj_, sel, rt;
      int rk;
      tb_ = BranchTarget & ~32'(IB - 1);
      tj_ = JumpTarget & ~32'(IB - 1);
      rk  = BranchTaken ? 1 : (Jump ? 2 : 0);
      rt  = (rk == 1) ? tb_ : tj_;
      sel = PCCurrent + 32'(IB);
      n_hold = 0; n_stalled = m_stalled; n_flush = 0;
      n_pv = m_pv; n_pbr = m_pbr; n_pt = m_pt;
      e_fv = 0; e_fl = 0;
      if (m_hold) begin
         sel = '0;
      end else if (m_flush > 0) begin
         e_fl = 1;
         if (BranchTaken) begin sel = tb_; n_flush = FC; end
         else n_flush = m_flush - 1;
      end else if (m_stalled) begin
         if (Stall) begin
            sel = PCCurrent;
            if (rk != 0 && !(m_pv && m_pbr && rk == 2)) begin
               n_pv = 1; n_pbr = (rk == 1); n_pt = rt;
            end
         end else begin
            n_stalled = 0;
            if (m_pv) begin sel = m_pt; n_pv = 0; n_flush = FC; end
            else if (rk != 0) begin sel = rt; n_flush = FC; end
         end
      end else begin
         e_fv = 1;
         if (rk != 0 && !Stall) begin
            sel = rt; n_flush = FC;
         end else if (Stall) begin
            sel = PCCurrent; n_stalled = 1;
            if (rk != 0) begin n_pv = 1; n_pbr = (rk == 1); n_pt = rt; end
         end
      end
      e_wr   = !m_hold && (sel > 32'(LA));
      e_addr = e_wr ? '0 : sel;
   endtask

   // One clock: drive, check against model (and optional fixed expectations),
   // then advance model across the edge. Entered/left at posedge+1.
   task automatic cyc(input logic [31:0] pc, input logic st, input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt,
                      input int xa = -1, input int xfl = -1, input int xwr = -1);
      PCCurrent = pc; Stall = st; BranchTaken = br; BranchTarget = bt; Jump = jp; JumpTarget = jt;
      #1;
      model_eval();
      chk("Address", Address, e_addr);
      chk("FetchValid", 32'(FetchValid), 32'(e_fv));
      chk("Flush", 32'(Flush), 32'(e_fl));
      chk("Wrapped", 32'(Wrapped), 32'(e_wr));
      if (xa >= 0)  chk("Address_plan", Address, 32'(xa));
      if (xfl >= 0) chk("Flush_plan", 32'(Flush), 32'(xfl));
      if (xwr >= 0) chk("Wrapped_plan", 32'(Wrapped), 32'(xwr));
      @(posedge Clk);
      m_hold = n_hold; m_stalled = n_stalled; m_flush = n_flush;
      m_pv = n_pv; m_pbr = n_pbr; m_pt = n_pt;
      nxt = e_addr;
      #1;
   endtask

   // Reset raised between edges; outputs must clear before any clock edge.
   task automatic do_reset();
      #2 Reset = 1'b1;
      #1;
      model_reset();
      chk("rst_Address", Address, 32'd0);
      chk("rst_FetchValid", 32'(FetchValid), 32'd0);
      chk("rst_Flush", 32'(Flush), 32'd0);
      chk("rst_Wrapped", 32'(Wrapped), 32'd0);
      @(posedge Clk); #1;
      Reset = 1'b0;
      nxt = '0;
   endtask

   initial begin
      Reset = 1'b1; Stall = 0; BranchTaken = 0; Jump = 0;
      PCCurrent = '0; BranchTarget = '0; JumpTarget = '0; nxt = '0;
      model_reset();
      @(posedge Clk); #1;
      do_reset();

      // Reset release: HOLD, then sequential fetch
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(nxt, 0, 0, 0, 0, 0, 4);
      cyc(nxt, 0, 0, 0, 0, 0, 8);
      cyc(nxt, 0, 0, 0, 0, 0, 12);

      // Branch with no stall, one flush cycle
      cyc(8, 0, 1, 20, 0, 0, 20, 0);
      cyc(20, 0, 0, 0, 0, 0, 24, 1);
      cyc(24, 0, 0, 0, 0, 0, 28, 0);

      // Stall with jump then branch buffered; later jump must not displace branch
      cyc(12, 1, 0, 0, 1, 32, 12);
      cyc(12, 1, 1, 4, 0, 0, 12);
      cyc(12, 1, 0, 0, 1, 32, 12);
      cyc(12, 0, 0, 0, 0, 0, 4, 0);
      cyc(4, 0, 0, 0, 0, 0, 8, 1);
      cyc(8, 0, 0, 0, 0, 0, 12, 0);

      // End-of-program wrap, sequential and via jump target
      cyc(36, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 4, 0, 0);
      cyc(4, 0, 0, 0, 1, 40, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 4, 1, 0);
      cyc(4, 0, 0, 0, 1, 36, 36, 0, 0);
      cyc(36, 0, 0, 0, 0, 0, 0, 1, 1);

      // Branch beats jump; unaligned target is aligned
      cyc(4, 0, 1, 16, 1, 28, 16, 0, 0);
      cyc(16, 0, 0, 0, 0, 0, 20, 1);
      cyc(20, 0, 1, 18, 0, 0, 16);
      cyc(16, 0, 0, 0, 1, 8, 20, 1);
      cyc(20, 0, 0, 0, 0, 0, 24, 0);

      // Reset while stalled with a pending target: stale target never issued
      cyc(8, 1, 1, 24, 0, 0, 8);
      cyc(8, 1, 0, 0, 0, 0, 8);
      do_reset();
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 4);
      cyc(4, 0, 0, 0, 0, 0, 8);

      // Reset in the middle of a flush
      cyc(8, 0, 1, 28, 0, 0, 28);
      do_reset();
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 4, 0);

      // Randomized traffic checked against the model
      for (int i = 0; i < 400; i++) begin
         logic [31:0] pc;
         if ($urandom_range(0, 69) == 0) begin
            do_reset();
         end else begin
            pc = nxt;
            if ($urandom_range(0, 4) == 0) pc = 32'($urandom_range(0, 12)) * 4;
            if ($urandom_range(0, 40) == 0) pc = 32'hFFFF_FFFC;
            cyc(pc, ($urandom_range(0, 9) < 3),
                ($urandom_range(0, 9) < 2), 32'($urandom_range(0, 47)),
                ($urandom_range(0, 9) < 2), 32'($urandom_range(0, 47)));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
